sobel_pixel_packer: RTL and testbench

Output-side companion of `sobel_filter`. It receives the filter's one-pixel-per-beat `PCIEPacket` stream and packs 16 grayscale bytes into each 128-bit `PCIEPacket` for the host. It marks the final packet of a frame with `last` and reports unused trailing bytes in `pad`. A small packet FIFO absorbs host backpressure.

---
 rtl/sobel_pixel_packer.sv | 195 +++++++++++++++++++
 tb/tb_sobel_pixel_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_pixel_packer.sv
// Packs the one-pixel-per-beat output of sobel_filter into 128-bit host packets
// of 16 grayscale bytes, tagging frame ends and padding, behind a small FWFT FIFO.
package sobel_pixel_packer_pkg;
  typedef struct packed {
    logic         valid;
    logic [127:0] data;
    logic [15:0]  slot;
    logic [3:0]   pad;
    logic         last;
  } PCIEPacket;
endpackage

module sobel_pixel_packer
  import sobel_pixel_packer_pkg::*;
#(
  parameter logic [15:0] SLOT       = 16'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  PCIEPacket   pcie_packet_in,
  input  logic [31:0] frame_pixels,
  input  logic        out_ready,
  output PCIEPacket   pcie_packet_out,
  output logic        overflow,
  output logic        frame_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_t;

  state_t         state_r;
  logic [127:0]   acc_r;
  logic [4:0]     count_r;
  logic [31:0]    remaining_r;
  logic           bounded_r;

  logic           pix_valid_s;
  logic [7:0]     pixel_s;
  logic [4:0]     cur_count_s;
  logic [31:0]    cur_rem_s;
  logic           cur_bounded_s;
  logic [4:0]     count_next_s;
  logic [4:0]     pad_full_s;
  logic [3:0]     pad_s;
  logic           last_s;
  logic           complete_s;
  logic [127:0]   merged_s;

  logic [127:0]   mem_data_r [FIFO_DEPTH];
  logic [3:0]     mem_pad_r  [FIFO_DEPTH];
  logic           mem_last_r [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic           empty_s;
  logic           full_s;
  logic           pop_s;
  logic           push_ok_s;
  logic           drop_s;
  logic           overflow_r;
  logic           frame_done_r;

  logic           unused_in_s;

  assign pix_valid_s = pcie_packet_in.valid;
  assign pixel_s     = pcie_packet_in.data[7:0];
  assign unused_in_s = ^{pcie_packet_in.data[127:8], pcie_packet_in.slot,
                         pcie_packet_in.pad, pcie_packet_in.last};

  // Selects the frame context for this pixel: a fresh frame in IDLE, the running one in PACK
  always_comb begin
    cur_count_s   = 5'd0;
    cur_rem_s     = frame_pixels;
    cur_bounded_s = (frame_pixels != 32'd0);
    case (state_r)
      IDLE: begin
        cur_count_s   = 5'd0;
        cur_rem_s     = frame_pixels;
        cur_bounded_s = (frame_pixels != 32'd0);
      end
      PACK: begin
        cur_count_s   = count_r;
        cur_rem_s     = remaining_r;
        cur_bounded_s = bounded_r;
      end
      default: begin
        cur_count_s   = 5'd0;
        cur_rem_s     = frame_pixels;
        cur_bounded_s = (frame_pixels != 32'd0);
      end
    endcase
  end

  // Inserts the incoming pixel at its byte lane on top of the accumulator
  always_comb begin
    merged_s = acc_r;
    for (int i = 0; i < 16; i++) begin
      if (cur_count_s == 5'(i)) begin
        merged_s[8*i +: 8] = pixel_s;
      end else begin
        merged_s[8*i +: 8] = acc_r[8*i +: 8];
      end
    end
  end

  // The frame ends on the pixel that takes a bounded remaining count from 1 to 0
  assign count_next_s = cur_count_s + 5'd1;
  assign last_s       = cur_bounded_s && (cur_rem_s == 32'd1);
  assign complete_s   = pix_valid_s && ((count_next_s == 5'd16) || last_s);
  assign pad_full_s   = 5'd16 - count_next_s;
  assign pad_s        = pad_full_s[3:0];

  // Packing state machine: accumulates bytes and tracks frame position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 128'd0;
      count_r     <= 5'd0;
      remaining_r <= 32'd0;
      bounded_r   <= 1'b0;
    end else if (pix_valid_s) begin
      remaining_r <= cur_bounded_s ? (cur_rem_s - 32'd1) : 32'd0;
      bounded_r   <= cur_bounded_s;
      if (complete_s) begin
        acc_r   <= 128'd0;
        count_r <= 5'd0;
        state_r <= last_s ? IDLE : PACK;
      end else begin
        acc_r   <= merged_s;
        count_r <= count_next_s;
        state_r <= PACK;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s     = !empty_s && out_ready;
  assign push_ok_s = complete_s && (!full_s || pop_s);
  assign drop_s    = complete_s && full_s && !pop_s;

  // Packet storage; contents are only visible through the valid-gated head
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_data_r[wr_ptr_r[AW-1:0]] <= merged_s;
      mem_pad_r[wr_ptr_r[AW-1:0]]  <= pad_s;
      mem_last_r[wr_ptr_r[AW-1:0]] <= last_s;
    end
  end

  // FIFO pointers, sticky overflow and frame completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      frame_done_r <= pop_s && mem_last_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Head of the FIFO drives the host packet; all fields read zero when empty
  always_comb begin
    pcie_packet_out = '0;
    if (!empty_s) begin
      pcie_packet_out.valid = 1'b1;
      pcie_packet_out.data  = mem_data_r[rd_ptr_r[AW-1:0]];
      pcie_packet_out.slot  = SLOT;
      pcie_packet_out.pad   = mem_pad_r[rd_ptr_r[AW-1:0]];
      pcie_packet_out.last  = mem_last_r[rd_ptr_r[AW-1:0]];
    end else begin
      pcie_packet_out = '0;
    end
  end

  assign overflow   = overflow_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sobel_pixel_packer.sv
// Directed bench for sobel_pixel_packer: table of frames plus hand-written
// backpressure, overflow, simultaneous push/pop and mid-frame reset sequences.
module tb_sobel_pixel_packer;
  import sobel_pixel_packer_pkg::*;

  localparam logic [15:0] SLOT_VAL = 16'hA5C3;
  localparam logic [127:0] PKT1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] PKT2 = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] PKT5 = 128'h4F4E4D4C4B4A49484746454443424140;

  logic        clk = 1'b0;
  logic        rst;
  PCIEPacket   pin;
  logic [31:0] fp;
  logic        out_ready;
  PCIEPacket   pout;
  logic        overflow;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  PCIEPacket cap[$];

  typedef struct {
    int unsigned  fp;
    int           n;
    logic [7:0]   first;
    logic [7:0]   step;
    int           gap;
    int           exp_cnt;
    logic [127:0] d_first;
    logic [3:0]   p_first;
    logic         l_first;
    logic [127:0] d_last;
    logic [3:0]   p_last;
    logic         l_last;
    int           exp_fd;
  } vec_t;

  vec_t vecs[6];

  sobel_pixel_packer #(.SLOT(SLOT_VAL), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pcie_packet_in  (pin),
    .frame_pixels    (fp),
    .out_ready       (out_ready),
    .pcie_packet_out (pout),
    .overflow        (overflow),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  // Records every transferred packet and every frame_done pulse
  always @(negedge clk) begin
    if (pout.valid && out_ready) cap.push_back(pout);
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v);
    @(posedge clk); #1;
    pin.valid = 1'b1;
    pin.data  = {{15{8'hEE}}, v};
    pin.slot  = 16'hFFFF;
    pin.pad   = 4'hF;
    pin.last  = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pin = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int cb;
    int fb;
    int nc;
    logic [7:0] px;
    cb = cap.size();
    fb = fd_cnt;
    fp = v.fp;
    px = v.first;
    for (int k = 0; k < v.n; k++) begin
      drive(px);
      px = px + v.step;
      if (k != v.n - 1) repeat (v.gap) idle();
    end
    @(negedge clk);
    chk("lat_pre_valid", 128'(pout.valid), 128'(1'b0));
    idle();
    @(negedge clk);
    chk("lat_post_valid", 128'(pout.valid), 128'(1'b1));
    repeat (4) @(negedge clk);
    nc = cap.size() - cb;
    chk("pkt_count", 128'(nc), 128'(v.exp_cnt));
    if (nc > 0) begin
      chk("first_data", cap[cb].data, v.d_first);
      chk("first_pad", 128'(cap[cb].pad), 128'(v.p_first));
      chk("first_last", 128'(cap[cb].last), 128'(v.l_first));
      chk("first_slot", 128'(cap[cb].slot), 128'(SLOT_VAL));
      chk("last_data", cap[cap.size()-1].data, v.d_last);
      chk("last_pad", 128'(cap[cap.size()-1].pad), 128'(v.p_last));
      chk("last_last", 128'(cap[cap.size()-1].last), 128'(v.l_last));
    end
    chk("frame_done_cnt", 128'(fd_cnt - fb), 128'(v.exp_fd));
  endtask

  initial begin
    int cb;
    int fb;
    logic [127:0] e;

    vecs[0] = '{fp:16, n:16, first:8'h00, step:8'h01, gap:0, exp_cnt:1,
                d_first:PKT1, p_first:4'd0, l_first:1'b1,
                d_last:PKT1, p_last:4'd0, l_last:1'b1, exp_fd:1};
    vecs[1] = '{fp:20, n:20, first:8'h01, step:8'h01, gap:0, exp_cnt:2,
                d_first:128'h100F0E0D0C0B0A090807060504030201, p_first:4'd0, l_first:1'b0,
                d_last:128'h14131211, p_last:4'd12, l_last:1'b1, exp_fd:1};
    vecs[2] = '{fp:3, n:3, first:8'hAA, step:8'h11, gap:2, exp_cnt:1,
                d_first:128'hCCBBAA, p_first:4'd13, l_first:1'b1,
                d_last:128'hCCBBAA, p_last:4'd13, l_last:1'b1, exp_fd:1};
    vecs[3] = '{fp:1, n:1, first:8'h5A, step:8'h01, gap:0, exp_cnt:1,
                d_first:128'h5A, p_first:4'd15, l_first:1'b1,
                d_last:128'h5A, p_last:4'd15, l_last:1'b1, exp_fd:1};
    vecs[4] = '{fp:17, n:17, first:8'h80, step:8'h01, gap:1, exp_cnt:2,
                d_first:128'h8F8E8D8C8B8A89888786858483828180, p_first:4'd0, l_first:1'b0,
                d_last:128'h90, p_last:4'd15, l_last:1'b1, exp_fd:1};
    vecs[5] = '{fp:0, n:32, first:8'h40, step:8'h01, gap:0, exp_cnt:2,
                d_first:PKT5, p_first:4'd0, l_first:1'b0,
                d_last:128'h5F5E5D5C5B5A59585756555453525150, p_last:4'd0, l_last:1'b0, exp_fd:0};

    pin = '0;
    fp = 32'd0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(pout.valid), 128'(1'b0));
    chk("rst_data", pout.data, 128'd0);
    chk("rst_pad_last_slot", 128'({pout.pad, pout.last, pout.slot}), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'(1'b0));
    chk("rst_frame_done", 128'(frame_done), 128'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Leave the unbounded frame behind before the backpressure sequence
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    out_ready = 1'b0;
    fp = 32'd80;
    fb = fd_cnt;
    for (int k = 0; k < 80; k++) begin
      drive(8'(k));
      if (k == 20 || k == 40) begin
        chk("hold_valid", 128'(pout.valid), 128'(1'b1));
        chk("hold_data", pout.data, PKT1);
      end
      if (k == 64) chk("ovf_before_drop", 128'(overflow), 128'(1'b0));
    end
    idle();
    chk("ovf_after_drop", 128'(overflow), 128'(1'b1));
    chk("hold_data_end", pout.data, PKT1);
    chk("hold_last_end", 128'(pout.last), 128'(1'b0));
    cb = cap.size();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain_count", 128'(cap.size() - cb), 128'd4);
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 16; j++) e[8*j +: 8] = 8'(16*p + j);
      if (cap.size() > cb + p) begin
        chk("drain_data", cap[cb+p].data, e);
        chk("drain_last", 128'(cap[cb+p].last), 128'(1'b0));
      end
    end
    chk("drain_frame_done", 128'(fd_cnt - fb), 128'd0);
    chk("ovf_sticky", 128'(overflow), 128'(1'b1));
    chk("drain_empty", 128'(pout.valid), 128'(1'b0));

    // Reset in the middle of a frame discards the partial packet
    fp = 32'd16;
    for (int k = 0; k < 7; k++) drive(8'(8'h30 + k));
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 128'(pout.valid), 128'(1'b0));
    chk("mid_rst_data", pout.data, 128'd0);
    chk("mid_rst_pad_last_slot", 128'({pout.pad, pout.last, pout.slot}), 128'd0);
    chk("mid_rst_overflow", 128'(overflow), 128'(1'b0));
    chk("mid_rst_frame_done", 128'(frame_done), 128'(1'b0));
    @(posedge clk); #1; rst = 1'b0;
    fp = 32'd4;
    cb = cap.size();
    for (int k = 1; k <= 4; k++) drive(8'(k));
    idle();
    repeat (4) @(negedge clk);
    chk("post_rst_count", 128'(cap.size() - cb), 128'd1);
    if (cap.size() > cb) begin
      chk("post_rst_data", cap[cb].data, 128'h04030201);
      chk("post_rst_pad", 128'(cap[cb].pad), 128'd12);
      chk("post_rst_last", 128'(cap[cb].last), 128'(1'b1));
    end

    // Fifth packet completes on the same edge the full FIFO pops its head
    out_ready = 1'b0;
    fp = 32'd80;
    cb = cap.size();
    fb = fd_cnt;
    for (int k = 0; k < 79; k++) drive(8'(k));
    drive(8'd79);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    @(negedge clk);
    chk("simul_overflow", 128'(overflow), 128'(1'b0));
    chk("simul_popped", 128'(cap.size() - cb), 128'd1);
    chk("simul_head", pout.data, PKT2);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("simul_total", 128'(cap.size() - cb), 128'd5);
    if (cap.size() >= cb + 5) begin
      chk("simul_last_data", cap[cb+4].data, PKT5);
      chk("simul_last_flag", 128'(cap[cb+4].last), 128'(1'b1));
      chk("simul_last_pad", 128'(cap[cb+4].pad), 128'd0);
    end
    chk("simul_frame_done", 128'(fd_cnt - fb), 128'd1);
    chk("simul_overflow_end", 128'(overflow), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
